// File: rtl/fta_reqbuf128.sv
// fta_reqbuf128 -- request-side buffer of the fta bus.
// One initiator's request stream is split by cid into CHANNELS responder
// channels. Each channel has a DEPTH-entry FIFO feeding a registered output,
// so a stalled responder never blocks requests bound for another channel.
// Optional feature: define FTA_REQBUF_BYPASS_EN to let a beat skip an empty
// FIFO and land directly in a free output register (1-cycle latency instead of 2).

package fta_reqbuf128_pkg;

  typedef struct packed {
    logic         cyc;
    logic         we;
    logic [3:0]   cid;
    logic [7:0]   tid;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] data;
  } fta_cmd_request128_t;

endpackage

module fta_reqbuf128
  import fta_reqbuf128_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DEPTH    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  fta_cmd_request128_t                 req,
  output logic                                req_stall,
  output fta_cmd_request128_t [CHANNELS-1:0]  req_o,
  input  logic [CHANNELS-1:0]                 ch_stall,
  output logic                                busy
);

  localparam int HBIT = $clog2(CHANNELS);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef FTA_REQBUF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [HBIT-1:0]                    ch;
  logic                               accept;
  fta_cmd_request128_t                fifo_mem [CHANNELS][DEPTH];
  logic [PW-1:0]                      rd_ptr_q [CHANNELS];
  logic [PW-1:0]                      rd_ptr_d [CHANNELS];
  logic [PW-1:0]                      wr_ptr_q [CHANNELS];
  logic [PW-1:0]                      wr_ptr_d [CHANNELS];
  logic [CW-1:0]                      count_q  [CHANNELS];
  logic [CW-1:0]                      count_d  [CHANNELS];
  fta_cmd_request128_t [CHANNELS-1:0] out_q;
  fta_cmd_request128_t [CHANNELS-1:0] out_d;
  logic [CHANNELS-1:0]                empty;
  logic [CHANNELS-1:0]                advance;
  logic [CHANNELS-1:0]                bypass;
  logic [CHANNELS-1:0]                push_fifo;
  logic [CHANNELS-1:0]                pop;

  // Steer the incoming beat; the stall uses the pre-pop count, so a slot freed
  // by a pop this cycle only becomes usable next cycle.
  always_comb begin
    ch        = req.cid[HBIT-1:0];
    req_stall = req.cyc & (count_q[ch] == FULL);
    accept    = req.cyc & ~req_stall;
  end

  // Per-channel FIFO control and output-register advance.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      empty[n]     = (count_q[n] == '0);
      advance[n]   = ~out_q[n].cyc | ~ch_stall[n];
      bypass[n]    = BYPASS & accept & (ch == HBIT'(n)) & empty[n] & advance[n];
      push_fifo[n] = accept & (ch == HBIT'(n)) & ~bypass[n];
      pop[n]       = advance[n] & ~empty[n];
      out_d[n]     = out_q[n];
      rd_ptr_d[n]  = rd_ptr_q[n];
      wr_ptr_d[n]  = wr_ptr_q[n];
      count_d[n]   = count_q[n];

      if (advance[n]) begin
        if (!empty[n])      out_d[n] = fifo_mem[n][rd_ptr_q[n]];
        else if (bypass[n]) out_d[n] = req;
        else                out_d[n] = '0;
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      if (pop[n])       rd_ptr_d[n] = rd_ptr_q[n] + PW'(1);
      if (push_fifo[n]) wr_ptr_d[n] = wr_ptr_q[n] + PW'(1);

      case ({push_fifo[n], pop[n]})
        2'b10:   count_d[n] = count_q[n] + CW'(1);
        2'b01:   count_d[n] = count_q[n] - CW'(1);
        default: count_d[n] = count_q[n];
      endcase
    end
  end

  // Busy whenever any channel holds a beat, in its FIFO or its output register.
  always_comb begin
    busy = 1'b0;
    for (int n = 0; n < CHANNELS; n++) begin
      busy = busy | (count_q[n] != '0) | out_q[n].cyc;
    end
  end

  assign req_o = out_q;

  // Control state: pointers, counts and output registers; reset discards queued beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < CHANNELS; n++) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        rd_ptr_q[n] <= '0;
        wr_ptr_q[n] <= '0;
        count_q[n]  <= '0;
      end
      out_q <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        rd_ptr_q[n] <= rd_ptr_d[n];
        wr_ptr_q[n] <= wr_ptr_d[n];
        count_q[n]  <= count_d[n];
      end
      out_q <= out_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count gates every read, so stale entries are never observed.
    for (int n = 0; n < CHANNELS; n++) begin
      if (push_fifo[n]) fifo_mem[n][wr_ptr_q[n]] <= req;
    end
  end

endmodule

// File: tb/tb_fta_reqbuf128.sv
// Self-checking bench for fta_reqbuf128: a table of directed vectors for the
// fill/stall/release corner, hand-written sequences for latency, per-channel
// isolation and reset, and a randomized run against a queue-based model.
module tb_fta_reqbuf128;
  import fta_reqbuf128_pkg::*;

  localparam int CHANNELS = 8;
  localparam int DEPTH    = 4;
`ifdef FTA_REQBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;

  logic                               clk;
  logic                               rst;
  fta_cmd_request128_t                req;
  logic                               req_stall;
  fta_cmd_request128_t [CHANNELS-1:0] req_o;
  logic [CHANNELS-1:0]                ch_stall;
  logic                               busy;

  fta_reqbuf128 #(.CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_stall (req_stall),
    .req_o     (req_o),
    .ch_stall  (ch_stall),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a queue of accepted, not-yet-consumed
  // beats; pres[n] says whether the head is currently shown on req_o[n].
  fta_cmd_request128_t mq [CHANNELS][$];
  bit                  pres [CHANNELS];

  fta_cmd_request128_t [CHANNELS-1:0] seen_o;
  logic                               seen_stall;

  typedef struct {
    logic       cyc;
    logic [7:0] tid;
    logic [7:0] stall;
    logic       exp_stall;
    logic       exp_busy;
    logic [7:0] exp_mask;
    logic [7:0] exp_tid;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] hdr(input fta_cmd_request128_t r);
    return {2'b00, r.cyc, r.we, r.cid, r.tid, r.sel, r.adr};
  endfunction

  function automatic fta_cmd_request128_t rand_req();
    fta_cmd_request128_t r;
    r.cyc  = 1'b1;
    r.we   = 1'($urandom);
    r.cid  = 4'($urandom);
    r.tid  = 8'($urandom);
    r.sel  = 16'($urandom);
    r.adr  = $urandom;
    r.data = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  function automatic fta_cmd_request128_t idle_req();
    fta_cmd_request128_t r;
    r = rand_req();
    r.cyc = 1'b0;
    return r;
  endfunction

  function automatic vec_t mk(logic cyc, logic [7:0] tid, logic [7:0] st, logic es,
                              logic eb, logic [7:0] em, logic [7:0] et);
    vec_t v;
    v.cyc = cyc; v.tid = tid; v.stall = st; v.exp_stall = es;
    v.exp_busy = eb; v.exp_mask = em; v.exp_tid = et;
    return v;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < CHANNELS; n++) begin
      mq[n].delete();
      pres[n] = 1'b0;
    end
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic do_reset();
    rst = 1'b0;
    req = idle_req();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // One cycle: drive, compare against the model, clock, advance the model.
  task automatic step(input fta_cmd_request128_t r, input logic [CHANNELS-1:0] s);
    fta_cmd_request128_t exp_o [CHANNELS];
    int fc [CHANNELS];
    int c;
    bit exp_stall, exp_busy;
    req = r;
    ch_stall = s;
    #2;
    c = int'(r.cid[2:0]);
    exp_busy = 1'b0;
    for (int n = 0; n < CHANNELS; n++) begin
      fc[n]    = mq[n].size() - int'(pres[n]);
      exp_o[n] = pres[n] ? mq[n][0] : '0;
      if (mq[n].size() != 0) exp_busy = 1'b1;
    end
    exp_stall = r.cyc && (fc[c] == DEPTH);
    check("req_stall", req_stall === exp_stall, 64'(req_stall), 64'(exp_stall));
    check("busy", busy === exp_busy, 64'(busy), 64'(exp_busy));
    for (int n = 0; n < CHANNELS; n++)
      check($sformatf("req_o[%0d]", n), req_o[n] === exp_o[n], hdr(req_o[n]), hdr(exp_o[n]));
    seen_o = req_o;
    seen_stall = req_stall;
    @(posedge clk);
    for (int n = 0; n < CHANNELS; n++) begin
      if (pres[n] && !s[n]) begin
        void'(mq[n].pop_front());
        pres[n] = 1'b0;
      end
      if (!pres[n] && fc[n] > 0) pres[n] = 1'b1;
      if (r.cyc && c == n && fc[n] < DEPTH) begin
        if (BYP && !pres[n] && fc[n] == 0) pres[n] = 1'b1;
        mq[n].push_back(r);
      end
    end
    @(negedge clk);
  endtask

  // Send nothing for a few cycles and record when/for how long channel ch shows a beat.
  task automatic latency_probe(input int ch, output int first, output int width);
    first = -1;
    width = 0;
    for (int i = 1; i <= 5; i++) begin
      step(idle_req(), '0);
      if (seen_o[ch].cyc) begin
        if (first < 0) first = i;
        width++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    fta_cmd_request128_t r;
    logic [CHANNELS-1:0] mask;
    int first, width, st0, st1;

    // Table: fill channel 2 (cid 0xA) while stalled, then release.
    tbl[0]  = mk(1, 0, 8'h04, 0, 0, 8'h00, 0);
    tbl[1]  = mk(1, 1, 8'h04, 0, 1, BYP ? 8'h04 : 8'h00, 0);
    tbl[2]  = mk(1, 2, 8'h04, 0, 1, 8'h04, 0);
    tbl[3]  = mk(1, 3, 8'h04, 0, 1, 8'h04, 0);
    tbl[4]  = mk(1, 4, 8'h04, 0, 1, 8'h04, 0);
    tbl[5]  = mk(1, 5, 8'h04, 1, 1, 8'h04, 0);
    tbl[6]  = mk(1, 5, 8'h04, 1, 1, 8'h04, 0);
    tbl[7]  = mk(1, 5, 8'h00, 1, 1, 8'h04, 0);
    tbl[8]  = mk(1, 5, 8'h00, 0, 1, 8'h04, 1);
    tbl[9]  = mk(0, 0, 8'h00, 0, 1, 8'h04, 2);
    tbl[10] = mk(0, 0, 8'h00, 0, 1, 8'h04, 3);
    tbl[11] = mk(0, 0, 8'h00, 0, 1, 8'h04, 4);
    tbl[12] = mk(0, 0, 8'h00, 0, 1, 8'h04, 5);
    tbl[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0);

    // Reset held with random traffic: everything stays quiet.
    rst = 1'b0;
    req = '0;
    ch_stall = '0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      req = rand_req();
      req.cyc = 1'($urandom);
      ch_stall = CHANNELS'($urandom);
      #2;
      for (int n = 0; n < CHANNELS; n++) mask[n] = req_o[n].cyc;
      check("rst_req_stall", req_stall === 1'b0, 64'(req_stall), 64'd0);
      check("rst_busy", busy === 1'b0, 64'(busy), 64'd0);
      check("rst_cyc_mask", mask === '0, 64'(mask), 64'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    req = idle_req();
    ch_stall = '0;
    @(negedge clk);

    // Table-driven fill / full-stall / release sequence.
    for (int i = 0; i < 14; i++) begin
      r = rand_req();
      r.cyc = tbl[i].cyc;
      r.cid = 4'hA;
      r.tid = tbl[i].tid;
      req = r;
      ch_stall = tbl[i].stall;
      #2;
      for (int n = 0; n < CHANNELS; n++) mask[n] = req_o[n].cyc;
      check($sformatf("tbl%0d_stall", i), req_stall === tbl[i].exp_stall, 64'(req_stall), 64'(tbl[i].exp_stall));
      check($sformatf("tbl%0d_busy", i), busy === tbl[i].exp_busy, 64'(busy), 64'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_mask", i), mask === tbl[i].exp_mask, 64'(mask), 64'(tbl[i].exp_mask));
      if (tbl[i].exp_mask[2]) begin
        check($sformatf("tbl%0d_tid", i), req_o[2].tid === tbl[i].exp_tid, 64'(req_o[2].tid), 64'(tbl[i].exp_tid));
        check($sformatf("tbl%0d_cid", i), req_o[2].cid === 4'hA, 64'(req_o[2].cid), 64'hA);
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Single beat on cid 3: nominal latency, one-cycle presentation, busy falls.
    do_reset();
    r = rand_req();
    r.cid = 4'd3;
    r.tid = 8'd5;
    step(r, '0);
    latency_probe(3, first, width);
    check("single_latency", first == LAT, 64'(first), 64'(LAT));
    check("single_width", width == 1, 64'(width), 64'd1);
    check("single_busy_after", busy === 1'b0, 64'(busy), 64'd0);

    // Alternating cid 0/1 with channel 0 stalled: only cid 0 beats ever stall.
    do_reset();
    st0 = 0;
    st1 = 0;
    for (int i = 0; i < 16; i++) begin
      r = rand_req();
      r.cid = 4'(i % 2);
      r.tid = 8'(i);
      step(r, 8'h01);
      if (seen_stall) begin
        if (i % 2 == 0) st0++;
        else st1++;
      end
    end
    check("iso_stall_cid0", st0 == 3, 64'(st0), 64'd3);
    check("iso_stall_cid1", st1 == 0, 64'(st1), 64'd0);

    // Reset mid-burst on cid 6: queued beats vanish, a new beat still flows.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      r = rand_req();
      r.cid = 4'd6;
      step(r, 8'h40);
    end
    rst = 1'b0;
    req = idle_req();
    #2;
    check("midrst_cyc6", req_o[6].cyc === 1'b0, 64'(req_o[6].cyc), 64'd0);
    check("midrst_busy", busy === 1'b0, 64'(busy), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(idle_req(), '0);
    r = rand_req();
    r.cid = 4'd6;
    step(r, '0);
    latency_probe(6, first, width);
    check("midrst_new_latency", first == LAT, 64'(first), 64'(LAT));
    check("midrst_new_width", width == 1, 64'(width), 64'd1);

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = rand_req();
      r.cyc = ($urandom_range(0, 3) != 0);
      step(r, CHANNELS'($urandom));
      if (i % 700 == 699) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
